// File: rtl/button_debouncer_if.sv
// Button pin plus conditioned level/pulse outputs of the push-button debouncer.
// The master modport is the debouncer side; slave is the pin driver / consumer side.
interface button_debouncer_if;
    logic btn_in;
    logic btn_level;
    logic press_pulse;
    logic release_pulse;
    logic long_press;
    logic repeat_pulse;

    modport master (
        input  btn_in,
        output btn_level,
        output press_pulse,
        output release_pulse,
        output long_press,
        output repeat_pulse
    );

    modport slave (
        output btn_in,
        input  btn_level,
        input  press_pulse,
        input  release_pulse,
        input  long_press,
        input  repeat_pulse
    );
endinterface

// File: rtl/button_debouncer.sv
// Push-button conditioner: 2-FF synchronizer, debounce FSM, long-press and auto-repeat timing.
// All outputs are registered; pulses are single-cycle and mutually exclusive.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES   = 120000,
    parameter int unsigned LONG_PRESS_CYCLES = 6000000,
    parameter int unsigned REPEAT_CYCLES     = 1200000,
    parameter int unsigned CNT_W             = 23,
    parameter bit          ACTIVE_LOW        = 1'b1
) (
    input  logic                clk,
    input  logic                rst_btn,
    button_debouncer_if.master  btn_if
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [1:0]       SYNC_RST  = {2{ACTIVE_LOW}};

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             level_q, level_d;
    logic             long_q, long_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             repeat_q, repeat_d;
    logic             pressed_c;

    // Synchronizer shift and polarity correction (pressed_c = 1 when pressed)
    always_comb begin
        sync_d    = {sync_q[0], btn_if.btn_in};
        pressed_c = sync_q[1] ^ ACTIVE_LOW;
    end

    // Debounce / hold FSM with long-press and repeat timing
    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        level_d    = level_q;
        long_d     = long_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        repeat_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pressed_c) begin
                    state_d  = DB_PRESS;
                    db_cnt_d = '0;
                end
            end

            DB_PRESS: begin
                if (!pressed_c) begin
                    state_d  = IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = HELD;
                    level_d    = 1'b1;
                    press_d    = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end

            HELD: begin
                // Leaving for release debounce freezes hold/repeat timing
                if (!pressed_c) begin
                    state_d  = DB_RELEASE;
                    db_cnt_d = '0;
                end else if (!long_q) begin
                    if (hold_cnt_q == LONG_LAST) begin
                        long_d    = 1'b1;
                        repeat_d  = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + CNT_ONE;
                    end
                end else if (rep_cnt_q == REP_LAST) begin
                    repeat_d  = 1'b1;
                    rep_cnt_d = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + CNT_ONE;
                end
            end

            DB_RELEASE: begin
                if (pressed_c) begin
                    state_d = HELD;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    level_d   = 1'b0;
                    long_d    = 1'b0;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state_q    <= IDLE;
            sync_q     <= SYNC_RST;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            level_q    <= 1'b0;
            long_q     <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            repeat_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            level_q    <= level_d;
            long_q     <= long_d;
            press_q    <= press_d;
            release_q  <= release_d;
            repeat_q   <= repeat_d;
        end
    end

    assign btn_if.btn_level     = level_q;
    assign btn_if.press_pulse   = press_q;
    assign btn_if.release_pulse = release_q;
    assign btn_if.long_press    = long_q;
    assign btn_if.repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: expected pulse events are queued with their cycle when the
// button is driven, and a negedge monitor pops and compares them as pulses appear.
module tb_button_debouncer;

    localparam int unsigned DB = 4;
    localparam int unsigned LP = 10;
    localparam int unsigned RP = 3;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_REPEAT  = 2;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_btn;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    ev_t  evq[$];
    int   exp_lp_rise = -1;
    int   exp_lp_fall = -1;
    logic prev_lvl = 1'b0;
    logic prev_lp = 1'b0;

    button_debouncer_if bif();

    button_debouncer #(
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LP),
        .REPEAT_CYCLES    (RP),
        .CNT_W            (23),
        .ACTIVE_LOW       (1'b1)
    ) dut (
        .clk    (clk),
        .rst_btn(rst_btn),
        .btn_if (bif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.cyc  = at;
        evq.push_back(e);
    endtask

    task automatic expect_ev(input int kind);
        ev_t e;
        check("ev_available", 32'(evq.size() > 0), 32'd1);
        if (evq.size() > 0) begin
            e = evq.pop_front();
            check("ev_kind", 32'(kind), 32'(e.kind));
            check("ev_cycle", 32'(cyc), 32'(e.cyc));
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic logic [31:0] outs();
        return 32'({bif.btn_level, bif.press_pulse, bif.release_pulse,
                    bif.long_press, bif.repeat_pulse});
    endfunction

    // Monitor: every pulse must match the next queued event; level/long edges are timed
    always @(negedge clk) begin : mon
        int np;
        if (rst_btn !== 1'b1) begin
            prev_lvl = 1'b0;
            prev_lp  = 1'b0;
        end else begin
            np = int'(bif.press_pulse) + int'(bif.release_pulse) + int'(bif.repeat_pulse);
            if (np > 1) check("pulse_exclusive", 32'(np), 32'd1);
            if (bif.press_pulse)   expect_ev(EV_PRESS);
            if (bif.release_pulse) expect_ev(EV_RELEASE);
            if (bif.repeat_pulse)  expect_ev(EV_REPEAT);
            if (bif.btn_level !== prev_lvl)
                check("level_edge_with_pulse", 32'(bif.press_pulse | bif.release_pulse), 32'd1);
            if (bif.long_press && !prev_lp) check("long_rise_cycle", 32'(cyc), 32'(exp_lp_rise));
            if (!bif.long_press && prev_lp) check("long_fall_cycle", 32'(cyc), 32'(exp_lp_fall));
            prev_lvl = bif.btn_level;
            prev_lp  = bif.long_press;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n, p, m, p3;
        rst_btn    = 1'b1;
        bif.btn_in = 1'b1;
        #2 rst_btn = 1'b0;

        // T1: toggling button under reset, then reset release with button up
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("t1_outs_in_reset", outs(), 32'd0);
            bif.btn_in = ~bif.btn_in;
        end
        @(negedge clk);
        bif.btn_in = 1'b1;
        rst_btn    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t1_outs_after_reset", outs(), 32'd0);
        end

        // T3: bounce shorter than the debounce window never produces a press
        n = cyc;
        bif.btn_in = 1'b0;
        wait_cyc(n + 3); bif.btn_in = 1'b1;
        wait_cyc(n + 4); bif.btn_in = 1'b0;
        wait_cyc(n + 7); bif.btn_in = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("t3_level_low", 32'(bif.btn_level), 32'd0);
        end

        // T2/T4/T5: clean press, long hold with repeats, bouncy release
        n = cyc;
        p = n + 7;
        m = p + 40;
        push_ev(EV_PRESS, p);
        for (int e = p + int'(LP); e <= m + 2; e += int'(RP)) push_ev(EV_REPEAT, e);
        push_ev(EV_RELEASE, m + 10);
        exp_lp_rise = p + int'(LP);
        exp_lp_fall = m + 10;
        bif.btn_in = 1'b0;
        wait_cyc(p - 1);
        check("t2_level_before_press", 32'(bif.btn_level), 32'd0);
        check("t2_no_early_press", 32'(bif.press_pulse), 32'd0);
        @(negedge clk);
        check("t2_press_pulse", 32'(bif.press_pulse), 32'd1);
        check("t2_level_at_press", 32'(bif.btn_level), 32'd1);
        @(negedge clk);
        check("t2_press_single_cycle", 32'(bif.press_pulse), 32'd0);
        wait_cyc(p + int'(LP) - 1);
        check("t4_long_before", 32'(bif.long_press), 32'd0);
        @(negedge clk);
        check("t4_long_at_threshold", 32'(bif.long_press), 32'd1);
        check("t4_first_repeat", 32'(bif.repeat_pulse), 32'd1);
        wait_cyc(m);
        bif.btn_in = 1'b1;
        wait_cyc(m + 2); bif.btn_in = 1'b0;
        wait_cyc(m + 3); bif.btn_in = 1'b1;
        wait_cyc(m + 9);
        check("t5_level_before_release", 32'(bif.btn_level), 32'd1);
        @(negedge clk);
        check("t5_release_pulse", 32'(bif.release_pulse), 32'd1);
        check("t5_level_falls", 32'(bif.btn_level), 32'd0);
        check("t5_long_falls", 32'(bif.long_press), 32'd0);
        repeat (6) @(negedge clk);
        check("t5_queue_drained", 32'(evq.size()), 32'd0);

        // T6: reset during long press, then re-debounce of the still-held button
        n = cyc;
        p = n + 7;
        push_ev(EV_PRESS, p);
        push_ev(EV_REPEAT, p + int'(LP));
        exp_lp_rise = p + int'(LP);
        bif.btn_in = 1'b0;
        wait_cyc(p + int'(LP) + 2);
        check("t6_long_before_reset", 32'(bif.long_press), 32'd1);
        #2 rst_btn = 1'b0;
        #1 check("t6_outs_async_reset", outs(), 32'd0);
        check("t6_queue_before_reset", 32'(evq.size()), 32'd0);
        evq.delete();
        repeat (3) @(negedge clk);
        check("t6_outs_held_reset", outs(), 32'd0);
        n  = cyc;
        p3 = n + 7;
        push_ev(EV_PRESS, p3);
        push_ev(EV_RELEASE, p3 + 9);
        rst_btn = 1'b1;
        wait_cyc(p3 - 1);
        check("t6_no_early_press", 32'(bif.press_pulse), 32'd0);
        @(negedge clk);
        check("t6_press_again", 32'(bif.press_pulse), 32'd1);
        wait_cyc(p3 + 2);
        bif.btn_in = 1'b1;
        wait_cyc(p3 + 9);
        check("t6_release_pulse", 32'(bif.release_pulse), 32'd1);
        repeat (5) @(negedge clk);
        check("final_queue_empty", 32'(evq.size()), 32'd0);
        check("final_outs_idle", outs(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions the raw mechanical push-button for the icestick LED counter designs. Produces a clean level and single-cycle press, release and auto-repeat pulses.
- Sits directly upstream of the counter logic. The counter increments on press_pulse/repeat_pulse instead of a divided clock, so all downstream logic stays in the 12 MHz clk domain.
- Contains a 2-FF synchronizer, a debounce FSM, and long-press/auto-repeat timing.

Parameters:
- DEBOUNCE_CYCLES, 120000, stable cycles required to accept a press or release (10 ms at 12 MHz); legal range >= 2.
- LONG_PRESS_CYCLES, 6000000, cycles in HELD before long_press asserts and the first repeat_pulse fires (0.5 s); legal range >= 1.
- REPEAT_CYCLES, 1200000, period of repeat_pulse after long press (100 ms); legal range >= 1.
- CNT_W, 23, counter width; all cycle parameters must be < 2^CNT_W.
- ACTIVE_LOW, 1, 1 = btn_in reads 0 when pressed.

Ports:
- clk  in  1  12 MHz oscillator.
- rst_btn  in  1  Reset, asynchronous, active-low. It asserts asynchronously; its deassertion is treated as synchronous to clk by the board.
- btn_in  in  1  Raw button pin; asynchronous and bouncy.
- btn_level  out  1  Debounced pressed state (1 = pressed).
- press_pulse  out  1  One clk cycle high on accepted press.
- release_pulse  out  1  One clk cycle high on accepted release.
- long_press  out  1  High from long-press threshold until accepted release.
- repeat_pulse  out  1  One-cycle pulse at the long-press threshold, then every REPEAT_CYCLES while held.

Behaviour:
- Reset (rst_btn=0, asynchronous):
  - state = IDLE; all counters = 0.
  - All outputs = 0.
  - Synchronizer flops reset to the released level (1 if ACTIVE_LOW, else 0).
  - Reset mid-operation aborts any press; no release_pulse is generated for it.
- Synchronizer: two flops on btn_in. p = synchronized value, polarity-corrected so that 1 = pressed.
- Timing reference: edge 0 is the first clk edge sampling btn_in asserted. p is seen by the FSM at edge 2.
- IDLE:
  - p=1 -> DB_PRESS, db_cnt=0.
  - Otherwise stay.
- DB_PRESS:
  - p=0 -> IDLE, db_cnt=0. Bounce restarts the debounce.
  - p=1 and db_cnt != DEBOUNCE_CYCLES-1 -> db_cnt+1.
  - p=1 and db_cnt == DEBOUNCE_CYCLES-1 -> HELD. Set btn_level=1, press_pulse=1 for one cycle, hold_cnt=0.
  - Net: press_pulse is high in the cycle after edge DEBOUNCE_CYCLES+2.
- HELD:
  - hold_cnt increments each cycle.
  - Threshold: when hold_cnt == LONG_PRESS_CYCLES-1 and long_press=0, set long_press=1, pulse repeat_pulse, and clear rep_cnt.
  - Repeat: while long_press=1, rep_cnt increments. When rep_cnt == REPEAT_CYCLES-1, pulse repeat_pulse and set rep_cnt=0.
  - hold_cnt saturates once long_press is set; no wrap.
  - p=0 -> DB_RELEASE, db_cnt=0. hold_cnt and rep_cnt freeze; no repeat pulses while in DB_RELEASE.
- DB_RELEASE:
  - p=1 -> HELD. Counters resume from frozen values; no new press_pulse.
  - p=0 and db_cnt == DEBOUNCE_CYCLES-1 -> IDLE. Set btn_level=0, long_press=0, release_pulse=1 for one cycle.
  - Otherwise db_cnt+1.
- Pulse rules:
  - press_pulse, release_pulse and repeat_pulse are registered outputs.
  - They are mutually exclusive; at most one is high in any cycle.
  - press_pulse and the first repeat_pulse are separated by LONG_PRESS_CYCLES cycles.
- btn_level changes only in the same cycle that press_pulse or release_pulse is high.
- The state encoding is unused-state safe: any illegal state returns to IDLE on the next edge.

Test Plan:
- Parameter overrides for all tests: DEBOUNCE=4, LONG=10, REPEAT=3, ACTIVE_LOW=1.
- T1: Hold rst_btn=0 while btn_in toggles, then release rst_btn -> all outputs 0 throughout; state IDLE.
- T2: Clean press. btn_in 1->0 at edge 0, held -> press_pulse high only in the cycle after edge 6; btn_level=1 from the same cycle.
- T3: Bounce. btn_in low 3 cycles, high 1, low 3, high -> no press_pulse, btn_level stays 0.
- T4: Long press held 40 cycles after press_pulse -> long_press rises 10 cycles after press_pulse with repeat_pulse. Further repeat_pulse every 3 cycles; none coincides with press_pulse.
- T5: Release bounce (high 2, low 1, high 5) -> one release_pulse 4 stable cycles after the final rise; btn_level and long_press fall in that cycle; no second press_pulse.
- T6: rst_btn pulsed low during HELD with long_press=1 -> all outputs 0 immediately. After reset, a held button re-debounces and press_pulse fires again after 4+2 cycles.
